// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the BCD down-counter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic bcd_digit_illegal(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_DIGIT_MAX);
  endfunction

  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp_digit(input logic [BCD_DIGIT_W-1:0] d);
    return bcd_digit_illegal(d) ? BCD_DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_dec.sv
// One-digit combinational BCD decrement with borrow.
// A digit above 9 simply steps down in binary and borrows only once it reaches 0.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   borrow_out
);

  always_comb begin
    borrow_out = borrow_in && (d == '0);
    if (!borrow_in) begin
      q = d;
    end else if (d == '0) begin
      q = BCD_DIGIT_MAX;
    end else begin
      q = d - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable DIGITS-digit BCD down-counter with done pulse and optional auto-reload.
// Build option BCD_LOAD_CHECK_EN: clamp illegal load digits to 9 and pulse err.
//
// Control inputs are level-sampled strobes; each rising edge resolves them with
// priority reset_n > load > stop > start > en. There is no back-pressure.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  en,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  zero,
  output logic                  done,
  output logic                  busy,
`ifdef BCD_LOAD_CHECK_EN
  output logic                  err,
`endif
  output state_t                state
);

  localparam int W = 4 * DIGITS;

  state_t         state_n;
  logic [W-1:0]   cnt_n;
  logic [W-1:0]   reload_reg;
  logic [W-1:0]   reload_n;
  logic [W-1:0]   cnt_dec;
  logic [W-1:0]   load_fix;
  logic [DIGITS:0] borrow;
  logic           done_n;

  assign borrow[0] = (state == ST_RUN) && en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dig (
      .d          (cnt[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .q          (cnt_dec[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

`ifdef BCD_LOAD_CHECK_EN
  logic load_bad;

  always_comb begin
    load_fix = load_val;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_digit_illegal(load_val[4*i +: 4])) begin
        load_bad = 1'b1;
      end
      load_fix[4*i +: 4] = bcd_clamp_digit(load_val[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= load && load_bad;
    end
  end
`else
  assign load_fix = load_val;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload_reg;
    done_n   = 1'b0;
    if (load) begin
      state_n  = ST_IDLE;
      cnt_n    = load_fix;
      reload_n = load_fix;
    end else if (stop) begin
      state_n = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (start && (cnt != '0)) begin
        state_n = ST_RUN;
      end
    end else if (en) begin
      // Borrow out of the top digit means this tick found the count already at 000.
      if (borrow[DIGITS]) begin
        if (auto_reload && (reload_reg != '0)) begin
          cnt_n = reload_reg;
        end else begin
          state_n = ST_IDLE;
        end
      end else begin
        cnt_n = cnt_dec;
        if (cnt_dec == '0) begin
          done_n = 1'b1;
          if (!auto_reload) begin
            state_n = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      reload_reg <= '0;
      zero       <= 1'b1;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      reload_reg <= reload_n;
      zero       <= (cnt_n == '0);
      done       <= done_n;
      busy       <= (state_n == ST_RUN);
    end
  end

endmodule
